// File: rtl/pkt_fifo_pkg.sv
// Shared types and width helpers for the per-pair packet FIFO.
package pkt_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } ser_state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pkt_serialiser.sv
// Latches a whole packet and streams it out one byte per cycle, flagging the
// final byte so the FIFO can commit the packet atomically.
module pkt_serialiser
  import pkt_fifo_pkg::*;
#(
  parameter int PKT_BYTES = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic                   i_flush,
  input  logic                   i_start,
  input  logic [PKT_BYTES*8-1:0] i_pkt_data,
  output logic [7:0]             o_byte,
  output logic                   o_wr,
  output logic                   o_commit,
  output logic                   o_busy
);

  localparam int REM_W = $clog2(PKT_BYTES + 1);

  ser_state_e             state_q;
  logic [PKT_BYTES*8-1:0] shift_q;
  logic [REM_W-1:0]       remain_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      remain_q <= '0;
    end else if (i_cg) begin
      if (i_flush) begin
        state_q  <= IDLE;
        remain_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start) begin
              shift_q  <= i_pkt_data;
              remain_q <= REM_W'(PKT_BYTES);
              state_q  <= FILL;
            end
          end
          FILL: begin
            shift_q  <= shift_q >> 8;
            remain_q <= remain_q - REM_W'(1);
            if (remain_q == REM_W'(1)) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Write and commit are qualified here so a flush cancels the byte in flight.
  assign o_byte   = shift_q[7:0];
  assign o_busy   = (state_q == FILL);
  assign o_wr     = o_busy && i_cg && !i_flush;
  assign o_commit = o_wr && (remain_q == REM_W'(1));

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO: accepts whole packets, stores bytes, and exposes them to the
// reader (first-word-fall-through) only after the full packet is committed.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int PKT_BYTES   = 8,
  parameter int DEPTH       = 16,
  parameter int DROPCOUNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [PKT_BYTES*8-1:0] i_pkt_data,
  input  logic                   i_pkt_valid,
  output logic                   o_pkt_drop,
  output logic [DROPCOUNT_W-1:0] o_dropCount,
  output logic [7:0]             o_data,
  output logic                   o_empty,
  input  logic                   i_pop,
  input  logic                   i_flush
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] PKT_CNT   = CNT_W'(PKT_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [7:0] mem [DEPTH];

  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]       fill_q, fill_d, avail_q, avail_d;
  logic [DROPCOUNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [7:0]       ser_byte;
  logic             ser_wr, ser_commit, ser_busy;
  logic             flush_s, pop_s, offer_s, accept_s, drop_s, space_ok_s;
  logic [CNT_W-1:0] fill_after_pop_s;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  pkt_serialiser #(.PKT_BYTES(PKT_BYTES)) u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_flush    (i_flush),
    .i_start    (accept_s),
    .i_pkt_data (i_pkt_data),
    .o_byte     (ser_byte),
    .o_wr       (ser_wr),
    .o_commit   (ser_commit),
    .o_busy     (ser_busy)
  );

  // Space is judged after this cycle's pop so a pop can make room for an offer.
  assign flush_s          = i_cg && i_flush;
  assign pop_s            = i_cg && i_pop && (avail_q != '0) && !i_flush;
  assign fill_after_pop_s = fill_q - CNT_W'(pop_s);
  assign space_ok_s       = (DEPTH_CNT - fill_after_pop_s) >= PKT_CNT;
  assign offer_s          = i_cg && i_pkt_valid && !i_flush && !i_rst;
  assign accept_s         = offer_s && !ser_busy && space_ok_s;
  assign drop_s           = offer_s && !accept_s;

  always_comb begin
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    fill_d     = fill_q;
    avail_d    = avail_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_s) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      fill_d   = '0;
      avail_d  = '0;
    end else begin
      rd_idx_d = pop_s  ? idx_inc(rd_idx_q) : rd_idx_q;
      wr_idx_d = ser_wr ? idx_inc(wr_idx_q) : wr_idx_q;
      fill_d   = fill_after_pop_s + (accept_s ? PKT_CNT : '0);
      avail_d  = avail_q - CNT_W'(pop_s) + (ser_commit ? PKT_CNT : '0);
    end
    if (drop_s && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROPCOUNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      fill_q     <= '0;
      avail_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      fill_q     <= fill_d;
      avail_q    <= avail_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ser_wr) begin
      mem[wr_idx_q] <= ser_byte;
    end
  end

  // Storage is unreset, so the head byte is forced to zero while nothing is committed.
  assign o_data      = (avail_q == '0) ? 8'h00 : mem[rd_idx_q];
  assign o_empty     = (avail_q == '0);
  assign o_pkt_drop  = drop_s;
  assign o_dropCount = drop_cnt_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed, table-driven bench for pkt_fifo (PKT_BYTES=4, DEPTH=10, DROPCOUNT_W=2).
module tb_pkt_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst, i_cg, i_pkt_valid, i_pop, i_flush;
  logic [31:0] i_pkt_data;
  logic        o_pkt_drop, o_empty;
  logic [1:0]  o_dropCount;
  logic [7:0]  o_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pkt;
    logic        pop;
    logic        flush;
    logic        cg;
    logic        exp_empty;
    logic [7:0]  exp_data;
    logic        exp_drop;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 i_clk = ~i_clk;

  pkt_fifo #(.PKT_BYTES(4), .DEPTH(10), .DROPCOUNT_W(2)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cg        (i_cg),
    .i_pkt_data  (i_pkt_data),
    .i_pkt_valid (i_pkt_valid),
    .o_pkt_drop  (o_pkt_drop),
    .o_dropCount (o_dropCount),
    .o_data      (o_data),
    .o_empty     (o_empty),
    .i_pop       (i_pop),
    .i_flush     (i_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic v, input logic [31:0] p, input logic pp,
                     input logic f, input logic cg, input logic e, input logic [7:0] d,
                     input logic dr, input logic [1:0] c);
    for (int i = 0; i < n; i++) vecs.push_back('{v, p, pp, f, cg, e, d, dr, c});
  endtask

  task automatic idle(input int n, input logic e, input logic [7:0] d, input logic [1:0] c);
    add(n, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, d, 1'b0, c);
  endtask

  task automatic pop1(input logic [7:0] d, input logic [1:0] c);
    add(1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0, c);
  endtask

  task automatic strobe(input logic [31:0] p, input logic e, input logic [7:0] d,
                        input logic dr, input logic [1:0] c);
    add(1, 1'b1, p, 1'b0, 1'b0, 1'b1, e, d, dr, c);
  endtask

  task automatic build_table();
    // basic packet: visible 5 cycles after the strobe, read in byte order
    strobe(32'h44332211, 1'b1, 8'h00, 1'b0, 2'd0);
    idle(4, 1'b1, 8'h00, 2'd0);
    pop1(8'h11, 2'd0); pop1(8'h22, 2'd0); pop1(8'h33, 2'd0); pop1(8'h44, 2'd0);
    idle(1, 1'b1, 8'h00, 2'd0);
    // two packets fill 8 of 10 bytes; third is dropped (B wraps past index 9)
    strobe(32'hA4A3A2A1, 1'b1, 8'h00, 1'b0, 2'd0);
    idle(4, 1'b1, 8'h00, 2'd0);
    strobe(32'hB4B3B2B1, 1'b0, 8'hA1, 1'b0, 2'd0);
    idle(4, 1'b0, 8'hA1, 2'd0);
    strobe(32'hC4C3C2C1, 1'b0, 8'hA1, 1'b1, 2'd0);
    pop1(8'hA1, 2'd1); pop1(8'hA2, 2'd1); pop1(8'hA3, 2'd1); pop1(8'hA4, 2'd1);
    pop1(8'hB1, 2'd1); pop1(8'hB2, 2'd1); pop1(8'hB3, 2'd1); pop1(8'hB4, 2'd1);
    idle(1, 1'b1, 8'h00, 2'd1);
    // strobe during FILL is dropped; first packet commits intact
    strobe(32'hD4D3D2D1, 1'b1, 8'h00, 1'b0, 2'd1);
    idle(1, 1'b1, 8'h00, 2'd1);
    strobe(32'hE4E3E2E1, 1'b1, 8'h00, 1'b1, 2'd1);
    idle(2, 1'b1, 8'h00, 2'd2);
    pop1(8'hD1, 2'd2); pop1(8'hD2, 2'd2); pop1(8'hD3, 2'd2); pop1(8'hD4, 2'd2);
    idle(1, 1'b1, 8'h00, 2'd2);
    // wrap-around, pop+accept and pop+commit in the same cycle
    strobe(32'hF4F3F2F1, 1'b1, 8'h00, 1'b0, 2'd2);
    idle(4, 1'b1, 8'h00, 2'd2);
    strobe(32'h57565554, 1'b0, 8'hF1, 1'b0, 2'd2);
    idle(4, 1'b0, 8'hF1, 2'd2);
    pop1(8'hF1, 2'd2); pop1(8'hF2, 2'd2); pop1(8'hF3, 2'd2); pop1(8'hF4, 2'd2);
    pop1(8'h54, 2'd2); pop1(8'h55, 2'd2);
    add(1, 1'b1, 32'h94939291, 1'b1, 1'b0, 1'b1, 1'b0, 8'h56, 1'b0, 2'd2);
    pop1(8'h57, 2'd2);
    idle(3, 1'b1, 8'h00, 2'd2);
    add(1, 1'b1, 32'h84838281, 1'b1, 1'b0, 1'b1, 1'b0, 8'h91, 1'b0, 2'd2);
    pop1(8'h92, 2'd2); pop1(8'h93, 2'd2);
    idle(1, 1'b0, 8'h94, 2'd2);
    pop1(8'h94, 2'd2);
    pop1(8'h81, 2'd2); pop1(8'h82, 2'd2); pop1(8'h83, 2'd2); pop1(8'h84, 2'd2);
    idle(1, 1'b1, 8'h00, 2'd2);
    // flush mid-FILL with a coincident strobe, then full 10-byte space
    strobe(32'h3C3B3A39, 1'b1, 8'h00, 1'b0, 2'd2);
    idle(1, 1'b1, 8'h00, 2'd2);
    add(1, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 2'd2);
    strobe(32'h74737271, 1'b1, 8'h00, 1'b0, 2'd2);
    idle(4, 1'b1, 8'h00, 2'd2);
    strobe(32'h64636261, 1'b0, 8'h71, 1'b0, 2'd2);
    idle(4, 1'b0, 8'h71, 2'd2);
    // saturation of the 2-bit drop counter, then clock gate holds everything
    strobe(32'hEEEEEEEE, 1'b0, 8'h71, 1'b1, 2'd2);
    strobe(32'hEEEEEEEE, 1'b0, 8'h71, 1'b1, 2'd3);
    strobe(32'hEEEEEEEE, 1'b0, 8'h71, 1'b1, 2'd3);
    add(1, 1'b1, 32'hEEEEEEEE, 1'b1, 1'b0, 1'b0, 1'b0, 8'h71, 1'b0, 2'd3);
    add(1, 1'b1, 32'hEEEEEEEE, 1'b1, 1'b1, 1'b0, 1'b0, 8'h71, 1'b0, 2'd3);
    pop1(8'h71, 2'd3); pop1(8'h72, 2'd3); pop1(8'h73, 2'd3); pop1(8'h74, 2'd3);
    pop1(8'h61, 2'd3); pop1(8'h62, 2'd3); pop1(8'h63, 2'd3); pop1(8'h64, 2'd3);
    idle(1, 1'b1, 8'h00, 2'd3);
  endtask

  initial begin
    int cycles;
    i_rst = 1'b1; i_cg = 1'b1; i_pkt_valid = 1'b0; i_pkt_data = 32'h0;
    i_pop = 1'b0; i_flush = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("reset_empty", 32'(o_empty), 32'd1);
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_drop", 32'(o_pkt_drop), 32'd0);
    check("reset_cnt", 32'(o_dropCount), 32'd0);

    build_table();
    foreach (vecs[k]) begin
      @(negedge i_clk);
      i_pkt_valid = vecs[k].valid;
      i_pkt_data  = vecs[k].pkt;
      i_pop       = vecs[k].pop;
      i_flush     = vecs[k].flush;
      i_cg        = vecs[k].cg;
      #1;
      check($sformatf("empty[%0d]", k), 32'(o_empty), 32'(vecs[k].exp_empty));
      check($sformatf("data[%0d]", k), 32'(o_data), 32'(vecs[k].exp_data));
      check($sformatf("drop[%0d]", k), 32'(o_pkt_drop), 32'(vecs[k].exp_drop));
      check($sformatf("cnt[%0d]", k), 32'(o_dropCount), 32'(vecs[k].exp_cnt));
    end

    // reset in the middle of a fill (with flush and strobe) restores reset state
    @(negedge i_clk);
    i_pop = 1'b0; i_flush = 1'b0; i_cg = 1'b1;
    i_pkt_valid = 1'b1; i_pkt_data = 32'h0D0C0B0A;
    @(negedge i_clk);
    i_pkt_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1; i_flush = 1'b1; i_pkt_valid = 1'b1;
    #1;
    check("rst_drop", 32'(o_pkt_drop), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_flush = 1'b0; i_pkt_valid = 1'b0;
    #1;
    check("rst_mid_empty", 32'(o_empty), 32'd1);
    check("rst_mid_data", 32'(o_data), 32'd0);
    check("rst_mid_cnt", 32'(o_dropCount), 32'd0);

    // fresh packet after reset: 5-cycle latency, head byte from index 0
    @(negedge i_clk);
    i_pkt_valid = 1'b1; i_pkt_data = 32'h2D2C2B2A;
    cycles = 0;
    while (cycles < 10) begin
      @(negedge i_clk);
      i_pkt_valid = 1'b0;
      #1;
      cycles++;
      if (!o_empty) break;
    end
    check("post_rst_latency", 32'(cycles), 32'd5);
    check("post_rst_data", 32'(o_data), 32'h2A);
    check("post_rst_empty", 32'(o_empty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
- Per-pair packet FIFO between the correlator's window-result logic (upstream) and the register/BytePipe block (downstream).
- Accepts a whole multi-byte result packet in one strobe and serialises it into byte storage at 1 byte/cycle.
- Exposes bytes to the reader only once the complete packet is committed, so a reader never sees a partial packet.
- Read side presents first-word-fall-through data with empty/pop/flush; one instance per correlator pair.

Parameters:
- PKT_BYTES, 8, bytes per packet (1..DEPTH).
- DEPTH, 16, storage in bytes; need not be a power of 2.
- DROPCOUNT_W, 8, width of the saturating drop counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_cg  input  1  clock-gate enable; when low, all state holds.
- i_pkt_data  input  PKT_BYTES*8  packet; byte 0 = bits [7:0], sent first.
- i_pkt_valid  input  1  single-cycle packet strobe; no backpressure.
- o_pkt_drop  output  1  pulse: the packet offered this cycle was dropped.
- o_dropCount  output  DROPCOUNT_W  saturating count of dropped packets.
- o_data  output  8  head byte; valid when !o_empty.
- o_empty  output  1  no committed bytes available.
- i_pop  input  1  consume the head byte.
- i_flush  input  1  discard all contents and abort any in-progress fill.

Behaviour:
- Reset values: o_empty=1, o_dropCount=0, o_pkt_drop=0, o_data=0 (don't-care while empty, but reset to 0). State=IDLE, all pointers and counts=0.
- State:
  - rdIdx, wrIdx, commitIdx: mod-DEPTH indices.
  - fill_q: bytes written or reserved, not yet popped.
  - avail_q: committed bytes not yet popped; o_empty = (avail_q == 0).
- FSM states: IDLE, FILL. Byte counter remain_q is clog2(PKT_BYTES+1) bits.
- IDLE, i_cg && i_pkt_valid && !i_flush:
  - If DEPTH - fill_q >= PKT_BYTES (evaluated with this cycle's pop applied first): latch i_pkt_data into a shift register, fill_q += PKT_BYTES, remain = PKT_BYTES, go to FILL.
  - Otherwise: o_pkt_drop=1 and o_dropCount += 1, saturating at all-ones.
- FILL, each cycle with i_cg high:
  - Write shift-register byte 0 at wrIdx, advance wrIdx, shift the register down, remain -= 1.
  - On the write where remain == 1: commitIdx <= new wrIdx, avail_q += PKT_BYTES, go to IDLE.
- i_pkt_valid while in FILL: dropped and counted, same as a full FIFO.
- Latency: strobe in cycle T → bytes written in cycles T+1..T+PKT_BYTES → o_empty falls in cycle T+PKT_BYTES+1. A new packet can be accepted in cycle T+PKT_BYTES+1 (1 idle-state cycle between back-to-back packets).
- Pop:
  - Effective when i_cg && i_pop && !o_empty: rdIdx advances, fill_q and avail_q decrement.
  - Pop when empty is ignored; it is not an error.
- Simultaneous events:
  - Pop and commit in the same cycle: avail_q += PKT_BYTES-1.
  - Pop and accept in the same cycle: space is checked against fill_q-1.
- Flush (i_cg && i_flush): has priority over pop, accept and fill.
  - All indices, fill_q and avail_q go to 0; state goes to IDLE; a partially written packet is discarded without commit.
  - A coincident i_pkt_valid is ignored: not stored, not counted.
  - o_dropCount is not cleared.
- Reset mid-FILL returns to the reset state identically; reset has priority over flush.
- Wrap-around: all indices wrap from DEPTH-1 to 0; arithmetic must be correct for non-power-of-2 DEPTH.
- o_data = mem[rdIdx], combinational from storage (FWFT).
- Storage has no reset.

Decomposition:
- Shared package: FSM state enum {IDLE, FILL}; localparam helpers for index width (clog2(DEPTH)) and count width (clog2(DEPTH+1)).
- One natural sub-module: pkt_serialiser, holding the shift register, remain counter and FSM. It emits a byte + write strobe + commit strobe; the top holds the storage, indices and counts.

Test Plan:
- PKT_BYTES=4, DEPTH=10. Strobe 0x44332211 at T → o_empty low at T+5; four pops return 0x11,0x22,0x33,0x44; o_empty high after the 4th pop.
- Same config, two packets accepted, then a third strobe with 2 free bytes → o_pkt_drop pulse, o_dropCount=1; FIFO contents unchanged.
- Strobe at T+2 during FILL → dropped and counted; the first packet commits intact.
- Fill, pop 6 bytes, add 2 packets → indices wrap past 9; read order is correct across the wrap.
- Flush at T+2 during FILL → o_empty stays high, state IDLE; the next packet is accepted with full space (10 bytes free); o_dropCount unchanged.
- DROPCOUNT_W=2, 5 drops → o_dropCount saturates at 3. Hold i_cg low with i_pkt_valid and i_pop asserted → no state change.
